priority_arbiter: RTL and testbench
===================================

# priority_arbiter

Parametrised, registered N-input priority encoder with request capture and a valid/ready output handshake. It generalises the 4-to-2 combinational encoder to any channel count. Request pulses are latched into a pending set, and the winning channel index is presented one grant at a time to a downstream consumer. Selection is either fixed priority (highest index wins, as in the combinational encoder) or rotating round-robin. The block sits between interrupt/request sources and a single consumer that services one channel per handshake.

## Interface
- N, 8, number of request channels; legal range 2..256
- W, $clog2(N), index width; derived, never overridden
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  N  request pulses/levels; bit i high in a cycle marks channel i pending
- rr_mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin
- ready  input  1  consumer accepts the presented grant this cycle
- Y  output  W  granted channel index (registered)
- valid  output  1  Y holds an unaccepted grant
- pending  output  N  registered pending set (channels captured but not yet presented)

## Operation
- Reset values: pending = 0, Y = 0, valid = 0, rotation pointer ptr = N-1.
- Load condition: load = (!valid || ready) && |pending.
- Selection, fixed mode: sel = highest set index of pending.
- Selection, round-robin mode: scan pending at indices ptr, ptr-1, …, 0, N-1, …, ptr+1; sel = first set index found.
- On load:
  - Y <= sel, valid <= 1.
  - pending[sel] is cleared, so the token moves into the output register.
  - ptr <= sel-1; if sel = 0, ptr <= N-1.
  - ptr updates on every load in either mode.
- When valid && ready && pending == 0: valid <= 0 and Y holds its last value.
- When valid && !ready: Y and valid hold, pending keeps accumulating, and ptr holds.
- Pending update each cycle: pending <= (pending & ~onehot(sel if load)) | req.
  - Set dominates clear: if req[sel] is high in the load cycle, the bit stays pending.
- Requests merge. A channel already pending is recorded once, with no counting.
- A request for the channel currently held in Y re-pends it, and it is granted again later.
- rr_mode is combinational into selection and may change on any cycle. The new mode applies from that cycle's selection, and ptr is never reset by a mode change.
- N not a power of 2: indices ≥ N are never produced, and the ptr wrap uses N-1, not 2^W-1.
- Reset mid-operation: all state clears asynchronously, and any outstanding grant or pending request is dropped.

## Timing
- Latency: req[i] sampled at edge E1 sets pending[i] after E1. If the output is free, Y = i and valid = 1 after E2, which is two edges from the sampled request.
- Throughput: one grant per cycle while ready = 1 and pending is non-empty.
- The handshake completes on the edge where valid && ready. The next grant, if any, is visible immediately after that same edge, with no bubble.
- Consumer rules:
  - ready may be asserted with valid low; it has no effect.
  - valid, once high, stays high and Y stays stable until accepted.
- pending reflects the register state, so a request sampled at edge E is visible on pending after E.
- Reset assertion forces all outputs to their reset values without waiting for a clock edge. Deassertion is synchronised externally; the first capture happens on the first edge after release.

## Test plan
- Reset, then N=4, fixed mode, req=4'b1010 for one cycle with ready=1 -> two edges later Y=3, valid=1; next cycle Y=1, valid=1; next cycle valid=0, pending=0.
- Backpressure: N=4, ready=0, req=4'b0001, then 4'b0100 -> Y=0 valid=1 holds; pending=4'b0100. Raising ready -> Y=2 on the next edge, then valid=0.
- Round-robin, N=4, req=4'b1111 held for 8 cycles with ready=1 -> grant sequence 3,2,1,0,3,2,1,0. Fixed mode with the same stimulus -> 3 every cycle.
- Set-dominates-clear: N=4, pending=4'b0100 being loaded while req[2]=1 in the same cycle -> Y=2 valid=1 and pending[2] still 1. The next grant is Y=2 again.
- Non-power-of-2, N=5, round-robin: grant index 0, then req=5'b10001 -> ptr wraps to 4 and the next grant is Y=4, never Y≥5.
- Async reset mid-stream: rst_n low between edges while valid=1, pending≠0 -> Y=0, valid=0, pending=0 immediately, with no clock edge. Round-robin after release starts from ptr=3 (N=4).

Source files
------------

// File: rtl/priority_arbiter.sv
// priority_arbiter
// Registered N-input priority encoder with request capture. Request pulses
// are merged into a pending set; one channel index at a time is moved into
// the output register and offered to a single consumer over valid/ready.
// Selection is fixed priority (highest index wins) or rotating round-robin,
// chosen combinationally by rr_mode on every cycle.
module priority_arbiter #(
  parameter int N = 8,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         rr_mode,
  input  logic         ready,
  output logic [W-1:0] Y,
  output logic         valid,
  output logic [N-1:0] pending
);

  // Pointer wraps to the last real channel, not to 2^W-1, so indices >= N
  // can never be scanned or granted when N is not a power of two.
  localparam logic [W-1:0] PTR_LAST = W'(N - 1);

  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] y_q, y_d;
  logic         valid_q, valid_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic [W-1:0] sel_fixed;
  logic [W-1:0] sel_rr;
  logic         found_rr;
  logic [W-1:0] sel;
  logic         load;

  // Fixed priority: the last set bit seen in an ascending scan is the highest.
  always_comb begin
    sel_fixed = '0;
    for (int i = 0; i < N; i++) begin
      if (pending_q[i]) begin
        sel_fixed = W'(i);
      end
    end
  end

  // Round-robin: scan downward from ptr, wrapping from 0 to N-1.
  always_comb begin
    int rr_idx;
    rr_idx   = 0;
    sel_rr   = '0;
    found_rr = 1'b0;
    for (int k = 0; k < N; k++) begin
      rr_idx = int'(ptr_q) - k;
      if (rr_idx < 0) begin
        rr_idx = rr_idx + N;
      end
      if (!found_rr && pending_q[rr_idx]) begin
        sel_rr   = W'(rr_idx);
        found_rr = 1'b1;
      end
    end
  end

  // Mode mux and load decision: load whenever the output slot is free or
  // being freed this cycle and something is waiting.
  always_comb begin
    sel  = rr_mode ? sel_rr : sel_fixed;
    load = (!valid_q || ready) && (|pending_q);
  end

  // Next-state: move the winning token into Y, retire an accepted grant,
  // and merge new requests (a request on the winning channel re-pends it).
  always_comb begin
    pending_d = pending_q;
    y_d       = y_q;
    valid_d   = valid_q;
    ptr_d     = ptr_q;
    if (load) begin
      pending_d[sel] = 1'b0;
      y_d            = sel;
      valid_d        = 1'b1;
      ptr_d          = (sel == '0) ? PTR_LAST : sel - W'(1);
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
    pending_d = pending_d | req;
  end

  // State registers; reset drops any outstanding grant and pending requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      y_q       <= '0;
      valid_q   <= 1'b0;
      ptr_q     <= PTR_LAST;
    end else begin
      pending_q <= pending_d;
      y_q       <= y_d;
      valid_q   <= valid_d;
      ptr_q     <= ptr_d;
    end
  end

  assign Y       = y_q;
  assign valid   = valid_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_priority_arbiter.sv
// Directed bench for priority_arbiter: one N=4 instance for the main
// scenarios and one N=5 instance for the non-power-of-two wrap.
module tb_priority_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic [3:0] req4;
  logic       rr4, rdy4, v4;
  logic [1:0] y4;
  logic [3:0] p4;

  logic [4:0] req5;
  logic       rr5, rdy5, v5;
  logic [2:0] y5;
  logic [4:0] p5;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  priority_arbiter #(.N(4)) u_arb4 (
    .clk(clk), .rst_n(rst_n), .req(req4), .rr_mode(rr4), .ready(rdy4),
    .Y(y4), .valid(v4), .pending(p4)
  );

  priority_arbiter #(.N(5)) u_arb5 (
    .clk(clk), .rst_n(rst_n), .req(req5), .rr_mode(rr5), .ready(rdy5),
    .Y(y5), .valid(v5), .pending(p5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req4 = '0; rr4 = 1'b0; rdy4 = 1'b0;
    req5 = '0; rr5 = 1'b0; rdy5 = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    vecs++;
    if (y4 !== 2'd0 || v4 !== 1'b0 || p4 !== 4'b0000) begin
      errs++; $display("FAIL reset_n4: got Y=%0d valid=%b pending=%b want 0/0/0000", y4, v4, p4);
    end
    vecs++;
    if (y5 !== 3'd0 || v5 !== 1'b0 || p5 !== 5'b00000) begin
      errs++; $display("FAIL reset_n5: got Y=%0d valid=%b pending=%b want 0/0/00000", y5, v5, p5);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    vecs++;
    if (v4 !== 1'b0 || p4 !== 4'b0000) begin
      errs++; $display("FAIL reset_idle: got valid=%b pending=%b want 0/0000", v4, p4);
    end
  endtask

  task automatic test_fixed();
    rr4 = 1'b0; rdy4 = 1'b1; req4 = 4'b1010;
    tick();
    vecs++;
    if (p4 !== 4'b1010 || v4 !== 1'b0) begin
      errs++; $display("FAIL fixed_capture: got pending=%b valid=%b want 1010/0", p4, v4);
    end
    req4 = 4'b0000;
    tick();
    vecs++;
    if (y4 !== 2'd3 || v4 !== 1'b1 || p4 !== 4'b0010) begin
      errs++; $display("FAIL fixed_grant3: got Y=%0d valid=%b pending=%b want 3/1/0010", y4, v4, p4);
    end
    tick();
    vecs++;
    if (y4 !== 2'd1 || v4 !== 1'b1 || p4 !== 4'b0000) begin
      errs++; $display("FAIL fixed_grant1: got Y=%0d valid=%b pending=%b want 1/1/0000", y4, v4, p4);
    end
    tick();
    vecs++;
    if (y4 !== 2'd1 || v4 !== 1'b0 || p4 !== 4'b0000) begin
      errs++; $display("FAIL fixed_drain: got Y=%0d valid=%b pending=%b want 1/0/0000", y4, v4, p4);
    end
  endtask

  task automatic test_backpressure();
    rr4 = 1'b0; rdy4 = 1'b0; req4 = 4'b0001;
    tick();
    vecs++;
    if (p4 !== 4'b0001 || v4 !== 1'b0) begin
      errs++; $display("FAIL bp_capture: got pending=%b valid=%b want 0001/0", p4, v4);
    end
    req4 = 4'b0100;
    tick();
    vecs++;
    if (y4 !== 2'd0 || v4 !== 1'b1 || p4 !== 4'b0100) begin
      errs++; $display("FAIL bp_grant0: got Y=%0d valid=%b pending=%b want 0/1/0100", y4, v4, p4);
    end
    req4 = 4'b0000;
    tick();
    vecs++;
    if (y4 !== 2'd0 || v4 !== 1'b1 || p4 !== 4'b0100) begin
      errs++; $display("FAIL bp_hold: got Y=%0d valid=%b pending=%b want 0/1/0100", y4, v4, p4);
    end
    rdy4 = 1'b1;
    tick();
    vecs++;
    if (y4 !== 2'd2 || v4 !== 1'b1 || p4 !== 4'b0000) begin
      errs++; $display("FAIL bp_release: got Y=%0d valid=%b pending=%b want 2/1/0000", y4, v4, p4);
    end
    tick();
    vecs++;
    if (y4 !== 2'd2 || v4 !== 1'b0) begin
      errs++; $display("FAIL bp_drain: got Y=%0d valid=%b want 2/0", y4, v4);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] rr_exp [8];
    rr_exp = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
    do_reset();
    rr4 = 1'b1; rdy4 = 1'b1; req4 = 4'b1111;
    tick();
    vecs++;
    if (p4 !== 4'b1111 || v4 !== 1'b0) begin
      errs++; $display("FAIL rr_capture: got pending=%b valid=%b want 1111/0", p4, v4);
    end
    for (int g = 0; g < 8; g++) begin
      tick();
      vecs++;
      if (y4 !== rr_exp[g] || v4 !== 1'b1) begin
        errs++; $display("FAIL rr_grant[%0d]: got Y=%0d valid=%b want %0d/1", g, y4, v4, rr_exp[g]);
      end
    end
  endtask

  task automatic test_fixed_stream_and_mode_switch();
    do_reset();
    rr4 = 1'b0; rdy4 = 1'b1; req4 = 4'b1111;
    tick();
    for (int g = 0; g < 8; g++) begin
      tick();
      vecs++;
      if (y4 !== 2'd3 || v4 !== 1'b1 || p4 !== 4'b1111) begin
        errs++; $display("FAIL fixed_stream[%0d]: got Y=%0d valid=%b pending=%b want 3/1/1111", g, y4, v4, p4);
      end
    end
    rr4 = 1'b1;
    tick();
    vecs++;
    if (y4 !== 2'd2 || v4 !== 1'b1) begin
      errs++; $display("FAIL mode_switch: got Y=%0d valid=%b want 2/1", y4, v4);
    end
  endtask

  task automatic test_set_dominates();
    do_reset();
    rr4 = 1'b0; rdy4 = 1'b1; req4 = 4'b0100;
    tick();
    vecs++;
    if (p4 !== 4'b0100) begin
      errs++; $display("FAIL sdc_capture: got pending=%b want 0100", p4);
    end
    tick();
    vecs++;
    if (y4 !== 2'd2 || v4 !== 1'b1 || p4 !== 4'b0100) begin
      errs++; $display("FAIL sdc_load: got Y=%0d valid=%b pending=%b want 2/1/0100", y4, v4, p4);
    end
    req4 = 4'b0000;
    tick();
    vecs++;
    if (y4 !== 2'd2 || v4 !== 1'b1 || p4 !== 4'b0000) begin
      errs++; $display("FAIL sdc_regrant: got Y=%0d valid=%b pending=%b want 2/1/0000", y4, v4, p4);
    end
    tick();
    vecs++;
    if (v4 !== 1'b0) begin
      errs++; $display("FAIL sdc_drain: got valid=%b want 0", v4);
    end
  endtask

  task automatic test_non_pow2();
    do_reset();
    rr5 = 1'b1; rdy5 = 1'b1; req5 = 5'b00001;
    tick();
    req5 = 5'b00000;
    tick();
    vecs++;
    if (y5 !== 3'd0 || v5 !== 1'b1) begin
      errs++; $display("FAIL np2_grant0: got Y=%0d valid=%b want 0/1", y5, v5);
    end
    req5 = 5'b10001;
    tick();
    vecs++;
    if (p5 !== 5'b10001 || v5 !== 1'b0) begin
      errs++; $display("FAIL np2_capture: got pending=%b valid=%b want 10001/0", p5, v5);
    end
    req5 = 5'b00000;
    tick();
    vecs++;
    if (y5 !== 3'd4 || v5 !== 1'b1 || p5 !== 5'b00001) begin
      errs++; $display("FAIL np2_wrap: got Y=%0d valid=%b pending=%b want 4/1/00001", y5, v5, p5);
    end
    tick();
    vecs++;
    if (y5 !== 3'd0 || v5 !== 1'b1 || p5 !== 5'b00000) begin
      errs++; $display("FAIL np2_next: got Y=%0d valid=%b pending=%b want 0/1/00000", y5, v5, p5);
    end
    rr5 = 1'b0; req5 = 5'b11111;
    tick();
    req5 = 5'b00000;
    tick();
    vecs++;
    if (y5 !== 3'd4 || v5 !== 1'b1) begin
      errs++; $display("FAIL np2_fixed: got Y=%0d valid=%b want 4/1", y5, v5);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    rr4 = 1'b1; rdy4 = 1'b0; req4 = 4'b0110;
    tick();
    req4 = 4'b0000;
    tick();
    vecs++;
    if (y4 !== 2'd2 || v4 !== 1'b1 || p4 !== 4'b0010) begin
      errs++; $display("FAIL ar_setup: got Y=%0d valid=%b pending=%b want 2/1/0010", y4, v4, p4);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vecs++;
    if (y4 !== 2'd0 || v4 !== 1'b0 || p4 !== 4'b0000) begin
      errs++; $display("FAIL ar_immediate: got Y=%0d valid=%b pending=%b want 0/0/0000", y4, v4, p4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rdy4 = 1'b1; req4 = 4'b1001;
    tick();
    vecs++;
    if (p4 !== 4'b1001 || v4 !== 1'b0) begin
      errs++; $display("FAIL ar_capture: got pending=%b valid=%b want 1001/0", p4, v4);
    end
    req4 = 4'b0000;
    tick();
    vecs++;
    if (y4 !== 2'd3 || v4 !== 1'b1) begin
      errs++; $display("FAIL ar_ptr_restart: got Y=%0d valid=%b want 3/1", y4, v4);
    end
    tick();
    vecs++;
    if (y4 !== 2'd0 || v4 !== 1'b1) begin
      errs++; $display("FAIL ar_second: got Y=%0d valid=%b want 0/1", y4, v4);
    end
    tick();
    vecs++;
    if (v4 !== 1'b0) begin
      errs++; $display("FAIL ar_drain: got valid=%b want 0", v4);
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_backpressure();
    test_round_robin();
    test_fixed_stream_and_mode_switch();
    test_set_dominates();
    test_non_pow2();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vecs);
    $fatal(1, "watchdog");
  end

endmodule
